// File: rtl/sar_share_scheduler.sv
// Round-robin scheduler that time-shares one SAR engine among NREQ requesters.
// Targets are clamped into the engine's legal range, and a watchdog aborts stuck transactions.
module sar_share_scheduler #(
  parameter int NREQ    = 4,
  parameter int TW      = 10,
  parameter int XW      = 4,
  parameter int TMIN    = 550,
  parameter int TMAX    = 1000,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*TW-1:0] req_target,
  output logic               rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [XW-1:0]      rsp_x,
  output logic [TW-1:0]      rsp_y,
  output logic               rsp_clipped,
  output logic               rsp_err,
  output logic               busy,
  output logic               sar_start,
  output logic [TW-1:0]      sar_target,
  input  logic               sar_done,
  input  logic [XW-1:0]      sar_x,
  input  logic [TW-1:0]      sar_y
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic [TW-1:0]   sar_target_q, sar_target_d;
  logic            clip_q, clip_d;
  logic [7:0]      wd_cnt_q, wd_cnt_d;
  logic [XW-1:0]   rsp_x_q, rsp_x_d;
  logic [TW-1:0]   rsp_y_q, rsp_y_d;
  logic            err_q, err_d;

  logic            grant_found;
  logic [IW-1:0]   grant_id;
  logic [IW:0]     cand;
  logic [TW-1:0]   raw_target;
  logic            timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      sar_target_q <= '0;
      clip_q       <= 1'b0;
      wd_cnt_q     <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_id_q     <= cur_id_d;
      sar_target_q <= sar_target_d;
      clip_q       <= clip_d;
      wd_cnt_q     <= wd_cnt_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      err_q        <= err_d;
    end
  end

  // First pending requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!grant_found && req[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IW-1:0];
      end
    end
  end

  assign raw_target = req_target[int'(grant_id)*TW +: TW];
  assign timed_out  = (wd_cnt_q == 8'(TIMEOUT));

  // sar_done is deliberately not looked at in ISSUE so a stale done cannot finish the new job.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sar_done || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cur_id_d     = cur_id_q;
    sar_target_d = sar_target_q;
    clip_d       = clip_q;
    wd_cnt_d     = wd_cnt_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cur_id_d = grant_id;
          if (raw_target < TW'(TMIN)) begin
            sar_target_d = TW'(TMIN);
            clip_d       = 1'b1;
          end else if (raw_target > TW'(TMAX)) begin
            sar_target_d = TW'(TMAX);
            clip_d       = 1'b1;
          end else begin
            sar_target_d = raw_target;
            clip_d       = 1'b0;
          end
        end
      end
      ISSUE: wd_cnt_d = '0;
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 8'd1;
        if (sar_done) begin
          rsp_x_d = sar_x;
          rsp_y_d = sar_y;
          err_d   = 1'b0;
        end else if (timed_out) begin
          rsp_x_d = '0;
          rsp_y_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP: rr_ptr_d = (cur_id_q == IW'(NREQ-1)) ? '0 : cur_id_q + IW'(1);
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == RESP);
    sar_start = (state_q == ISSUE);
    busy      = (state_q != IDLE);
  end

  assign rsp_id      = 3'(cur_id_q);
  assign rsp_x       = rsp_x_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_clipped = clip_q;
  assign rsp_err     = err_q;
  assign sar_target  = sar_target_q;

endmodule

// File: tb/tb_sar_share_scheduler.sv
// Self-checking bench for sar_share_scheduler: a table of single transactions plus
// hand-written round-robin, stale-done and reset-during-WAIT sequences.
module tb_sar_share_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] req_target;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [3:0]  rsp_x;
  logic [9:0]  rsp_y;
  logic        rsp_clipped;
  logic        rsp_err;
  logic        busy;
  logic        sar_start;
  logic [9:0]  sar_target;
  logic        sar_done;
  logic [3:0]  sar_x;
  logic [9:0]  sar_y;

  int nChecks = 0;
  int nErrors = 0;

  int eng_lat;
  logic eng_stuck;
  int eng_cnt;
  logic eng_pulse;

  typedef struct {
    logic [3:0] req;
    int tgt;
    int lat;
    int exp_tgt;
    int exp_id;
    int exp_x;
    int exp_y;
    int exp_clip;
    int exp_err;
    int exp_cyc;
  } vec_t;

  vec_t vecs[10];

  int rrId[5]  = '{0, 1, 2, 3, 0};
  int rrTgt[5] = '{630, 780, 700, 1000, 630};
  int rrX[5]   = '{12, 7, 10, 0, 12};
  int rrY[5]   = '{640, 790, 700, 1000, 640};

  sar_share_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_target  (req_target),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_x       (rsp_x),
    .rsp_y       (rsp_y),
    .rsp_clipped (rsp_clipped),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .sar_start   (sar_start),
    .sar_target  (sar_target),
    .sar_done    (sar_done),
    .sar_x       (sar_x),
    .sar_y       (sar_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: raises done for one cycle eng_lat cycles after start (0 = never);
  // eng_stuck holds done high regardless.
  initial begin
    eng_cnt   = 0;
    eng_pulse = 1'b0;
    sar_done  = 1'b0;
    sar_x     = '0;
    sar_y     = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      eng_cnt   = 0;
      eng_pulse = 1'b0;
    end else if (sar_start) begin
      eng_cnt   = eng_lat;
      eng_pulse = 1'b0;
      sar_x     = 4'((1000 - int'(sar_target)) / 30);
      sar_y     = 10'(1000 - 30 * ((1000 - int'(sar_target)) / 30));
    end else if (eng_cnt > 0) begin
      eng_cnt   = eng_cnt - 1;
      eng_pulse = (eng_cnt == 0);
    end else begin
      eng_pulse = 1'b0;
    end
    sar_done = eng_pulse | eng_stuck;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int tgt, input int lat);
    req_target = '0;
    for (int i = 0; i < 4; i++)
      if (r[i]) req_target[i*10 +: 10] = 10'(tgt);
    eng_lat = lat;
  endtask

  // Drives req from a negedge and waits for rsp_valid; returns with the response still on the outputs.
  task automatic runTxn(input logic [3:0] r, input logic keep,
                        output int startCnt, output int stTgt, output int cyc, output logic got);
    int startAt;
    startCnt = 0;
    stTgt    = -1;
    cyc      = -1;
    got      = 1'b0;
    startAt  = -1;
    req      = r;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sar_start) begin
        startCnt++;
        stTgt = int'(sar_target);
        if (startAt < 0) startAt = c;
      end
      if (rsp_valid) begin
        got = 1'b1;
        cyc = c - startAt;
        if (!keep) req = '0;
        break;
      end
    end
    if (!got) begin
      req = '0;
      checkOutput("response wait bound", 0, 1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rsp_valid"}, int'(rsp_valid), 0);
    checkOutput({tag, " rsp_id"}, int'(rsp_id), 0);
    checkOutput({tag, " rsp_x"}, int'(rsp_x), 0);
    checkOutput({tag, " rsp_y"}, int'(rsp_y), 0);
    checkOutput({tag, " rsp_clipped"}, int'(rsp_clipped), 0);
    checkOutput({tag, " rsp_err"}, int'(rsp_err), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " sar_start"}, int'(sar_start), 0);
    checkOutput({tag, " sar_target"}, int'(sar_target), 0);
  endtask

  initial begin
    int sc, st, cy;
    logic got;
    int seen;

    vecs[0] = '{4'b0001,  630, 5,  630, 0, 12,  640, 0, 0,  6};
    vecs[1] = '{4'b0010,  400, 5,  550, 1, 15,  550, 1, 0,  6};
    vecs[2] = '{4'b0100, 1023, 5, 1000, 2,  0, 1000, 1, 0,  6};
    vecs[3] = '{4'b1000,  550, 5,  550, 3, 15,  550, 0, 0,  6};
    vecs[4] = '{4'b0001, 1000, 3, 1000, 0,  0, 1000, 0, 0,  4};
    vecs[5] = '{4'b0010, 1001, 5, 1000, 1,  0, 1000, 1, 0,  6};
    vecs[6] = '{4'b0100,  549, 5,  550, 2, 15,  550, 1, 0,  6};
    vecs[7] = '{4'b0010,  700, 0,  700, 1,  0,    0, 0, 1, 17};
    vecs[8] = '{4'b0001,  630, 5,  630, 0, 12,  640, 0, 0,  6};
    vecs[9] = '{4'b1000,  780, 2,  780, 3,  7,  790, 0, 0,  3};

    rst        = 1'b1;
    req        = '0;
    req_target = '0;
    eng_lat    = 5;
    eng_stuck  = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].req, vecs[v].tgt, vecs[v].lat);
      runTxn(vecs[v].req, 1'b0, sc, st, cy, got);
      if (got) begin
        checkOutput($sformatf("vec%0d start count", v), sc, 1);
        checkOutput($sformatf("vec%0d sar_target", v), st, vecs[v].exp_tgt);
        checkOutput($sformatf("vec%0d rsp_id", v), int'(rsp_id), vecs[v].exp_id);
        checkOutput($sformatf("vec%0d rsp_x", v), int'(rsp_x), vecs[v].exp_x);
        checkOutput($sformatf("vec%0d rsp_y", v), int'(rsp_y), vecs[v].exp_y);
        checkOutput($sformatf("vec%0d rsp_clipped", v), int'(rsp_clipped), vecs[v].exp_clip);
        checkOutput($sformatf("vec%0d rsp_err", v), int'(rsp_err), vecs[v].exp_err);
        checkOutput($sformatf("vec%0d cycles", v), cy, vecs[v].exp_cyc);
        checkOutput($sformatf("vec%0d busy in RESP", v), int'(busy), 1);
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d idle after", v), int'(busy), 0);
    end

    // Round-robin from a fresh rr_ptr with all four requests held high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_lat    = 5;
    req_target = {10'd1000, 10'd700, 10'd780, 10'd630};
    for (int n = 0; n < 5; n++) begin
      runTxn(4'hF, (n < 4), sc, st, cy, got);
      if (got) begin
        checkOutput($sformatf("rr%0d start count", n), sc, 1);
        checkOutput($sformatf("rr%0d sar_target", n), st, rrTgt[n]);
        checkOutput($sformatf("rr%0d rsp_id", n), int'(rsp_id), rrId[n]);
        checkOutput($sformatf("rr%0d rsp_x", n), int'(rsp_x), rrX[n]);
        checkOutput($sformatf("rr%0d rsp_y", n), int'(rsp_y), rrY[n]);
        checkOutput($sformatf("rr%0d cycles", n), cy, 6);
      end
    end
    @(negedge clk);

    // Stale done held high across two grants: each response must come from the first WAIT cycle.
    eng_stuck = 1'b1;
    applyStimulus(4'b0001, 630, 5);
    runTxn(4'b0001, 1'b0, sc, st, cy, got);
    if (got) begin
      checkOutput("stale A cycles", cy, 2);
      checkOutput("stale A rsp_x", int'(rsp_x), 12);
      checkOutput("stale A rsp_y", int'(rsp_y), 640);
      checkOutput("stale A rsp_err", int'(rsp_err), 0);
    end
    @(negedge clk);
    applyStimulus(4'b0100, 700, 5);
    runTxn(4'b0100, 1'b0, sc, st, cy, got);
    if (got) begin
      checkOutput("stale B cycles", cy, 2);
      checkOutput("stale B rsp_id", int'(rsp_id), 2);
      checkOutput("stale B rsp_x", int'(rsp_x), 10);
      checkOutput("stale B rsp_y", int'(rsp_y), 700);
    end
    eng_stuck = 1'b0;
    @(negedge clk);

    // Reset mid-WAIT: transaction abandoned, rr_ptr back to 0 so requester 0 wins next.
    applyStimulus(4'b0100, 700, 0);
    req  = 4'b0100;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sar_start) begin
        seen = 1;
        break;
      end
    end
    checkOutput("rst-wait issue seen", seen, 1);
    repeat (3) @(negedge clk);
    checkOutput("rst-wait busy before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("mid-wait reset");
    rst = 1'b0;
    req = '0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("no rsp after reset", seen, 0);
    eng_lat    = 5;
    req_target = {10'd1000, 10'd700, 10'd780, 10'd630};
    runTxn(4'hF, 1'b0, sc, st, cy, got);
    if (got) begin
      checkOutput("post-reset rsp_id", int'(rsp_id), 0);
      checkOutput("post-reset sar_target", st, 630);
      checkOutput("post-reset rsp_x", int'(rsp_x), 12);
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/sar_share_scheduler.md
# sar_share_scheduler

Round-robin scheduler that time-shares one successive-approximation engine (4-bit code `x`, `y = 1000 - 30*x`) among several requesters. It picks a pending requester, clamps the requester's target into the engine's legal range, and pulses the engine's `start`. It then waits for `done` under a watchdog and returns `x`/`y` tagged with the requester's ID. It sits between the client blocks and the single shared engine instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TW`, 10: target / `y` width.
- `XW`, 4: code width.
- `TMIN`, 550: lower clamp bound for targets.
- `TMAX`, 1000: upper clamp bound for targets.
- `TIMEOUT`, 15: maximum WAIT cycles before the transaction is aborted (1..255).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: per-requester request level; held high until own `rsp_valid`.
- `req_target` in NREQ*TW: packed targets; requester i uses bits [i*TW +: TW].
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_id` out 3: index of the requester served.
- `rsp_x` out XW: engine code result.
- `rsp_y` out TW: engine value result.
- `rsp_clipped` out 1: target was clamped.
- `rsp_err` out 1: watchdog expired.
- `busy` out 1: state != IDLE.
- `sar_start` out 1: one-cycle start pulse to the engine.
- `sar_target` out TW: clamped target, held stable from ISSUE through WAIT.
- `sar_done` in 1: engine completion, level or pulse.
- `sar_x` in XW: engine code output.
- `sar_y` in TW: engine value output.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` bit is high, choose the winner by round-robin starting at `rr_ptr`, searching upward with wrap at NREQ-1 -> 0.
  - Register `cur_id` = winner.
  - Register `sar_target` = clamp(target[winner]).
  - Register `clip` = (raw < TMIN) || (raw > TMAX).
  - Go to ISSUE.
  - If no request is pending, stay in IDLE.
- Clamp rule: raw < TMIN -> TMIN; raw > TMAX -> TMAX; otherwise raw. Comparisons are unsigned, full TW bits.
- ISSUE: `sar_start`=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT. `sar_done` is ignored in this cycle, because a stale done from the previous transaction must not complete the new one.
- WAIT: increment the watchdog counter each cycle.
  - `sar_done`=1 -> capture `sar_x`/`sar_y` into the response registers, `err`=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT -> `rsp_x`=0, `rsp_y`=0, `err`=1, go to RESP.
  - If done and the timeout occur in the same cycle, done wins (`err`=0).
- RESP: `rsp_valid`=1 for one cycle with `rsp_id`=`cur_id` and the captured fields. Set `rr_ptr` = (`cur_id`+1) mod NREQ. Go to IDLE.
- A requester whose `req` drops before being granted is simply skipped.
- `req` from the served requester is ignored during RESP. It may be re-granted only after every other pending requester has been served once.
- Target is sampled only at grant. Changes afterwards do not affect the transaction in flight.

## Timing
- Reset (synchronous, any state including mid-WAIT) sets the following on the next edge:
  - State IDLE, `rr_ptr`=0.
  - Outputs zero: `rsp_valid`, `rsp_id`, `rsp_x`, `rsp_y`, `rsp_clipped`, `rsp_err`, `busy`, `sar_start`, `sar_target`.
  - An in-flight transaction is abandoned with no response.
  - The engine is reset by its own reset, not by this block.
- `req` seen at edge E0 (IDLE) -> ISSUE after E0 (`sar_start`=1) -> WAIT after E1.
- `sar_done` first sampled high at edge Ek (k ≥ 2) -> `rsp_valid` high in the cycle after Ek.
- Back-to-back: IDLE occupies one cycle between RESP and the next ISSUE. Minimum request-to-request period is therefore engine latency + 3 cycles.
- `busy` is registered and equals 1 in ISSUE, WAIT and RESP.
- Timeout response: `rsp_valid` appears exactly TIMEOUT+2 cycles after the ISSUE cycle starts.

## Test plan
- Single request: `req`=0001, target0=630, engine model done 5 cycles after start with x=12, y=640.
  - Required: exactly one `sar_start` pulse with `sar_target`=630.
  - Required: `rsp_valid` with id=0, x=12, y=640, clipped=0, err=0.
- Clamping: target=400 -> `sar_target`=550, `rsp_clipped`=1. Target=1023 -> `sar_target`=1000, `rsp_clipped`=1. Target=550 and target=1000 -> passed through unchanged, clipped=0.
- Round-robin: all four `req` held high continuously with targets 630/780/700/1000.
  - Required: responses in id order 0,1,2,3,0, with no requester served twice before the others.
  - Required: each `sar_target` matches its requester's target.
- Watchdog: engine model never asserts done, TIMEOUT=15.
  - Required: `rsp_valid` 17 cycles after the start of ISSUE, with err=1, x=0, y=0.
  - Required: scheduler returns to IDLE and serves the next request normally.
- Stale done: hold `sar_done`=1 continuously from the previous transaction into the next grant.
  - Required: ISSUE ignores it; the response is taken in the first WAIT cycle, never in ISSUE.
- Reset mid-WAIT: assert `rst` for 1 cycle during WAIT.
  - Required: no `rsp_valid`, all outputs 0 next cycle, `rr_ptr`=0, so requester 0 wins the next arbitration.
